// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use, MDU busy and branch-operand hazards plus a memory freeze.
// Latency: stall/flush/freeze/cause are combinational in the same cycle; the MDU tracker and stall counter update on i_clk.
// Backpressure: i_dmem_ready low freezes the whole pipe and masks stall/flush; the stall counter keeps counting frozen cycles.
//
// Ports:
//   i_clk, i_reset                       clock and asynchronous active-high reset
//   i_branch_id, i_branch_taken          branch decoded in ID and resolved taken in ID
//   i_rs_id, i_rt_id, i_rs/rt_used_id    ID source registers and whether each one is actually read
//   i_rt_ex, i_rd_ex, i_memread_ex,
//   i_regwrite_ex                        EX stage load destination and ALU write-back
//   i_rd_mem, i_regwrite_mem,
//   i_memtoreg_mem                       MEM stage write-back
//   i_mdu_start_ex, i_mdu_use_id         MDU op issued in EX, ID instruction reads HI/LO
//   i_dmem_ready, i_cnt_clr              data memory ready, stall-counter clear
//   o_stall, o_flush_idex, o_flush_ifid,
//   o_freeze                             pipeline control
//   o_mdu_busy, o_cause, o_stall_cycles  MDU status, stall reason, stall/freeze cycle count
module hazard_ctrl_unit #(
    parameter int REG_W      = 5,
    parameter int MDU_LAT    = 4,
    parameter int CNT_W      = 16,
    parameter int BR_FWD_MEM = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_branch_id,
    input  logic             i_branch_taken,
    input  logic [REG_W-1:0] i_rs_id,
    input  logic [REG_W-1:0] i_rt_id,
    input  logic             i_rs_used_id,
    input  logic             i_rt_used_id,
    input  logic [REG_W-1:0] i_rt_ex,
    input  logic [REG_W-1:0] i_rd_ex,
    input  logic             i_memread_ex,
    input  logic             i_regwrite_ex,
    input  logic [REG_W-1:0] i_rd_mem,
    input  logic             i_regwrite_mem,
    input  logic             i_memtoreg_mem,
    input  logic             i_mdu_start_ex,
    input  logic             i_mdu_use_id,
    input  logic             i_dmem_ready,
    input  logic             i_cnt_clr,
    output logic             o_stall,
    output logic             o_flush_idex,
    output logic             o_flush_ifid,
    output logic             o_freeze,
    output logic             o_mdu_busy,
    output logic [1:0]       o_cause,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic {M_IDLE, M_BUSY} mdu_state_t;

    localparam logic [3:0]       LAT_LOAD = 4'(MDU_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    mdu_state_t mdu_state;
    logic [3:0] mdu_cnt;

    logic load_use;
    logic mdu_haz;
    logic br_haz;
    logic ex_hit;
    logic mem_hit;
    logic mem_src_wr;

    // True when register r is read by the instruction in ID.
    function automatic logic src_match(input logic [REG_W-1:0] r);
        return (i_rs_used_id && (i_rs_id == r)) || (i_rt_used_id && (i_rt_id == r));
    endfunction

    assign o_freeze = !i_dmem_ready;

    assign load_use = i_memread_ex && (i_rt_ex != '0) && src_match(i_rt_ex);
    assign mdu_haz  = i_mdu_use_id && o_mdu_busy;

    // With MEM forwarding into the branch comparator only loads in MEM still
    // have to wait; without it any MEM write-back to a branch source stalls.
    assign mem_src_wr = (BR_FWD_MEM != 0) ? i_memtoreg_mem : i_regwrite_mem;
    assign ex_hit     = i_regwrite_ex && (i_rd_ex != '0) && src_match(i_rd_ex);
    assign mem_hit    = mem_src_wr && (i_rd_mem != '0) && src_match(i_rd_mem);
    assign br_haz     = i_branch_id && (ex_hit || mem_hit);

    assign o_stall      = !o_freeze && (load_use || mdu_haz || br_haz);
    assign o_flush_idex = o_stall;
    assign o_flush_ifid = i_branch_taken && !o_stall && !o_freeze;

    always_comb begin
        o_cause = 2'd0;
        if (o_freeze)      o_cause = 2'd3;
        else if (load_use) o_cause = 2'd1;
        else if (mdu_haz)  o_cause = 2'd2;
        else if (br_haz)   o_cause = 2'd3;
    end

    // MDU tracker: a start while frozen is not accepted; a start while busy
    // reloads the full latency. Decrement continues through freezes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mdu_state <= M_IDLE;
            mdu_cnt   <= 4'd0;
        end else if (i_mdu_start_ex && !o_freeze) begin
            mdu_state <= M_BUSY;
            mdu_cnt   <= LAT_LOAD;
        end else if (mdu_state == M_BUSY) begin
            if (mdu_cnt == 4'd1) begin
                mdu_state <= M_IDLE;
                mdu_cnt   <= 4'd0;
            end else begin
                mdu_cnt <= mdu_cnt - 4'd1;
            end
        end
    end

    assign o_mdu_busy = (mdu_state == M_BUSY);

    // Saturating stall/freeze cycle counter; clear wins over increment.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stall_cycles <= '0;
        end else if (i_cnt_clr) begin
            o_stall_cycles <= '0;
        end else if ((o_stall || o_freeze) && (o_stall_cycles != CNT_MAX)) begin
            o_stall_cycles <= o_stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: two instances share all inputs, one with MEM branch forwarding, one without.
// Inputs change 1 ns after the rising edge; outputs are sampled later in the same cycle.
// Both instances use CNT_W=4 so counter saturation is reachable quickly.
module tb_hazard_ctrl_unit;

    localparam int REG_W = 5;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_branch_id, i_branch_taken;
    logic [REG_W-1:0] i_rs_id, i_rt_id, i_rt_ex, i_rd_ex, i_rd_mem;
    logic             i_rs_used_id, i_rt_used_id;
    logic             i_memread_ex, i_regwrite_ex, i_regwrite_mem, i_memtoreg_mem;
    logic             i_mdu_start_ex, i_mdu_use_id, i_dmem_ready, i_cnt_clr;

    logic       stall1, flush_idex1, flush_ifid1, freeze1, busy1;
    logic [1:0] cause1;
    logic [3:0] cyc1;
    logic       stall0, flush_idex0, flush_ifid0, freeze0, busy0;
    logic [1:0] cause0;
    logic [3:0] cyc0;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    hazard_ctrl_unit #(.REG_W(REG_W), .MDU_LAT(4), .CNT_W(4), .BR_FWD_MEM(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_branch_id(i_branch_id), .i_branch_taken(i_branch_taken),
        .i_rs_id(i_rs_id), .i_rt_id(i_rt_id),
        .i_rs_used_id(i_rs_used_id), .i_rt_used_id(i_rt_used_id),
        .i_rt_ex(i_rt_ex), .i_rd_ex(i_rd_ex),
        .i_memread_ex(i_memread_ex), .i_regwrite_ex(i_regwrite_ex),
        .i_rd_mem(i_rd_mem), .i_regwrite_mem(i_regwrite_mem), .i_memtoreg_mem(i_memtoreg_mem),
        .i_mdu_start_ex(i_mdu_start_ex), .i_mdu_use_id(i_mdu_use_id),
        .i_dmem_ready(i_dmem_ready), .i_cnt_clr(i_cnt_clr),
        .o_stall(stall1), .o_flush_idex(flush_idex1), .o_flush_ifid(flush_ifid1),
        .o_freeze(freeze1), .o_mdu_busy(busy1), .o_cause(cause1), .o_stall_cycles(cyc1)
    );

    hazard_ctrl_unit #(.REG_W(REG_W), .MDU_LAT(4), .CNT_W(4), .BR_FWD_MEM(0)) dut_nofwd (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_branch_id(i_branch_id), .i_branch_taken(i_branch_taken),
        .i_rs_id(i_rs_id), .i_rt_id(i_rt_id),
        .i_rs_used_id(i_rs_used_id), .i_rt_used_id(i_rt_used_id),
        .i_rt_ex(i_rt_ex), .i_rd_ex(i_rd_ex),
        .i_memread_ex(i_memread_ex), .i_regwrite_ex(i_regwrite_ex),
        .i_rd_mem(i_rd_mem), .i_regwrite_mem(i_regwrite_mem), .i_memtoreg_mem(i_memtoreg_mem),
        .i_mdu_start_ex(i_mdu_start_ex), .i_mdu_use_id(i_mdu_use_id),
        .i_dmem_ready(i_dmem_ready), .i_cnt_clr(i_cnt_clr),
        .o_stall(stall0), .o_flush_idex(flush_idex0), .o_flush_ifid(flush_ifid0),
        .o_freeze(freeze0), .o_mdu_busy(busy0), .o_cause(cause0), .o_stall_cycles(cyc0)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_branch_id = 0; i_branch_taken = 0;
        i_rs_id = '0; i_rt_id = '0; i_rs_used_id = 0; i_rt_used_id = 0;
        i_rt_ex = '0; i_rd_ex = '0; i_memread_ex = 0; i_regwrite_ex = 0;
        i_rd_mem = '0; i_regwrite_mem = 0; i_memtoreg_mem = 0;
        i_mdu_start_ex = 0; i_mdu_use_id = 0; i_dmem_ready = 1; i_cnt_clr = 0;
    endtask

    task automatic set_load_use();
        i_memread_ex = 1; i_rt_ex = 5'd8; i_rs_id = 5'd8; i_rs_used_id = 1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        i_reset = 1;
        #2;
        // Reset state with quiet inputs.
        chk("rst_busy",   8'(busy1), 8'd0);
        chk("rst_cycles", 8'(cyc1), 8'd0);
        chk("rst_stall",  8'(stall1), 8'd0);
        chk("rst_flush",  8'(flush_idex1), 8'd0);
        chk("rst_ifid",   8'(flush_ifid1), 8'd0);
        chk("rst_freeze", 8'(freeze1), 8'd0);
        chk("rst_cause",  8'(cause1), 8'd0);
        tick();
        i_reset = 0;
        tick();

        // Load-use on rs.
        set_load_use();
        #1;
        chk("lu_stall", 8'(stall1), 8'd1);
        chk("lu_flush", 8'(flush_idex1), 8'd1);
        chk("lu_cause", 8'(cause1), 8'd1);
        i_rs_used_id = 0;
        #1;
        chk("lu_unused_stall", 8'(stall1), 8'd0);
        chk("lu_unused_cause", 8'(cause1), 8'd0);
        i_rs_used_id = 1; i_rt_ex = 5'd0; i_rs_id = 5'd0;
        #1;
        chk("lu_r0_stall", 8'(stall1), 8'd0);
        // Load-use through rt.
        i_rt_ex = 5'd9; i_rs_id = 5'd1; i_rt_id = 5'd9; i_rt_used_id = 1;
        #1;
        chk("lu_rt_stall", 8'(stall1), 8'd1);
        tick();
        idle_inputs();

        // Branch operand produced by an ALU op in MEM.
        i_branch_id = 1; i_regwrite_mem = 1; i_memtoreg_mem = 0;
        i_rd_mem = 5'd5; i_rt_id = 5'd5; i_rt_used_id = 1;
        #1;
        chk("br_fwd_stall",   8'(stall1), 8'd0);
        chk("br_nofwd_stall", 8'(stall0), 8'd1);
        chk("br_nofwd_cause", 8'(cause0), 8'd3);
        // Load in MEM feeding the branch stalls in both modes.
        i_memtoreg_mem = 1;
        #1;
        chk("br_memload_stall", 8'(stall1), 8'd1);
        chk("br_memload_cause", 8'(cause1), 8'd3);
        // ALU result still in EX.
        i_memtoreg_mem = 0; i_regwrite_mem = 0;
        i_regwrite_ex = 1; i_rd_ex = 5'd5;
        #1;
        chk("br_ex_stall", 8'(stall1), 8'd1);
        // Taken branch is flushed only when not stalled.
        i_branch_taken = 1;
        #1;
        chk("br_taken_stalled_ifid", 8'(flush_ifid1), 8'd0);
        i_regwrite_ex = 0;
        #1;
        chk("br_taken_ifid", 8'(flush_ifid1), 8'd1);
        tick();
        idle_inputs();

        // Freeze masks stall and flush, and blocks MDU start.
        set_load_use();
        i_branch_taken = 1; i_dmem_ready = 0; i_mdu_start_ex = 1;
        #1;
        chk("frz_freeze", 8'(freeze1), 8'd1);
        chk("frz_stall",  8'(stall1), 8'd0);
        chk("frz_flush",  8'(flush_idex1), 8'd0);
        chk("frz_ifid",   8'(flush_ifid1), 8'd0);
        chk("frz_cause",  8'(cause1), 8'd3);
        tick();
        chk("frz_no_mdu_start", 8'(busy1), 8'd0);
        idle_inputs();

        // MDU latency 4 with HI/LO reader waiting in ID.
        i_mdu_use_id = 1; i_mdu_start_ex = 1;
        tick();                             // edge N
        i_mdu_start_ex = 0;
        chk("mdu_busy_n",  8'(busy1), 8'd1);
        chk("mdu_stall_n", 8'(stall1), 8'd1);
        chk("mdu_cause_n", 8'(cause1), 8'd2);
        for (int k = 1; k <= 3; k++) begin
            tick();                         // edges N+1..N+3
            chk($sformatf("mdu_stall_n%0d", k), 8'(stall1), 8'd1);
        end
        tick();                             // edge N+4
        chk("mdu_stall_n4", 8'(stall1), 8'd0);
        chk("mdu_busy_n4",  8'(busy1), 8'd0);

        // Restart two cycles into an op extends busy through N+5.
        i_mdu_start_ex = 1;
        tick();                             // N
        i_mdu_start_ex = 0;
        tick();                             // N+1
        i_mdu_start_ex = 1;
        tick();                             // N+2 reload
        i_mdu_start_ex = 0;
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("mdu_re_busy_n%0d", k), 8'(busy1), 8'd1);
            tick();
        end
        chk("mdu_re_busy_n6", 8'(busy1), 8'd0);
        idle_inputs();

        // Stall counter: clear, saturate, clear beats increment.
        i_cnt_clr = 1;
        tick();
        i_cnt_clr = 0;
        chk("cnt_clear", 8'(cyc1), 8'd0);
        set_load_use();
        for (int k = 0; k < 3; k++) tick();
        chk("cnt_three", 8'(cyc1), 8'd3);
        for (int k = 3; k < 20; k++) tick();
        chk("cnt_sat", 8'(cyc1), 8'd15);
        i_cnt_clr = 1;
        tick();
        i_cnt_clr = 0;
        chk("cnt_clr_prio", 8'(cyc1), 8'd0);
        tick();
        chk("cnt_after_clr", 8'(cyc1), 8'd1);
        idle_inputs();

        // Reset in the middle of an MDU op.
        i_mdu_start_ex = 1;
        tick();
        i_mdu_start_ex = 0;
        tick();
        chk("rmid_busy_before", 8'(busy1), 8'd1);
        #1;
        i_reset = 1;
        #1;
        chk("rmid_busy_async", 8'(busy1), 8'd0);
        chk("rmid_cycles",     8'(cyc1), 8'd0);
        tick();
        i_reset = 0;
        for (int k = 0; k < 4; k++) tick();
        chk("rmid_busy_after", 8'(busy1), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-002 SHALL have parameter MDU_LAT, default 4, range 2..15, meaning multiply/divide latency in cycles.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 SHALL have parameter BR_FWD_MEM, default 1; 1 means ALU results in MEM are forwarded to the ID branch comparator, 0 means they are not.
REQ-005 SHALL have port i_clk, input, 1, sole clock, rising edge; i_reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have inputs i_branch_id (1, branch in ID), i_branch_taken (1, branch resolved taken in ID), i_rs_id / i_rt_id (REG_W, ID sources) and i_rs_used_id / i_rt_used_id (1, source actually read).
REQ-007 SHALL have inputs i_rt_ex (REG_W, load destination), i_rd_ex (REG_W, EX write register), i_memread_ex (1), i_regwrite_ex (1).
REQ-008 SHALL have inputs i_rd_mem (REG_W), i_regwrite_mem (1) and i_memtoreg_mem (1).
REQ-009 SHALL have inputs i_mdu_start_ex (1, MDU op in EX), i_mdu_use_id (1, ID reads HI/LO), i_dmem_ready (1, data memory ready) and i_cnt_clr (1, synchronous counter clear).
REQ-010 SHALL have outputs o_stall (1, hold PC and IF/ID), o_flush_idex (1, bubble into ID/EX), o_flush_ifid (1), o_freeze (1, hold all stages), o_mdu_busy (1), o_cause (2) and o_stall_cycles (CNT_W).

Function
REQ-011 SHALL drive o_freeze = !i_dmem_ready combinationally.
REQ-012 SHALL define load_use = i_memread_ex & (i_rt_ex != 0) & ((i_rs_used_id & i_rs_id == i_rt_ex) | (i_rt_used_id & i_rt_id == i_rt_ex)).
REQ-013 SHALL define mdu_haz = i_mdu_use_id & o_mdu_busy.
REQ-014 SHALL define br_haz = i_branch_id & (ex_hit | mem_hit); ex_hit = i_regwrite_ex & i_rd_ex != 0 & i_rd_ex matches a used ID source; mem_hit = (BR_FWD_MEM ? i_memtoreg_mem : i_regwrite_mem) & i_rd_mem != 0 & i_rd_mem matches a used ID source.
REQ-015 SHALL drive o_stall = o_flush_idex = !o_freeze & (load_use | mdu_haz | br_haz), combinationally, in the same cycle as the condition.
REQ-016 SHALL drive o_flush_ifid = i_branch_taken & !o_stall & !o_freeze.
REQ-017 SHALL drive o_cause with priority: 3 when o_freeze, else 1 when load_use, else 2 when mdu_haz, else 3 when br_haz, else 0.
REQ-018 SHALL implement the MDU tracker as a two-state FSM (M_IDLE, M_BUSY) with a 4-bit down-counter; o_mdu_busy = (state == M_BUSY).
REQ-019 SHALL accept an MDU start at a rising edge where i_mdu_start_ex=1 and o_freeze=0: load counter with MDU_LAT and enter M_BUSY.
REQ-020 SHALL, in M_BUSY with no accepted start, decrement the counter each edge, freeze included, and return to M_IDLE at the edge where the counter equals 1; o_mdu_busy is thus high exactly MDU_LAT cycles after the start edge.
REQ-021 SHALL treat a start accepted in M_BUSY as a reload to MDU_LAT; reload has priority over decrement.
REQ-022 SHALL increment o_stall_cycles at each edge where o_stall | o_freeze, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL clear o_stall_cycles to 0 at an edge where i_cnt_clr=1, with priority over increment.

Reset
REQ-024 SHALL, on i_reset high, asynchronously force the FSM to M_IDLE, the counter to 0, o_mdu_busy to 0 and o_stall_cycles to 0.
REQ-025 SHALL abandon an in-progress MDU op on reset mid-operation; after release, o_mdu_busy stays 0 until a new start.
REQ-026 SHALL keep combinational outputs as functions of inputs during reset; with i_dmem_ready=1 and no hazard inputs they are all 0.

Verification
REQ-027 Load-use: i_memread_ex=1, i_rt_ex=8, i_rs_id=8, i_rs_used_id=1 -> o_stall=o_flush_idex=1, o_cause=1; same stimulus with i_rs_used_id=0 or i_rt_ex=0 -> all 0.
REQ-028 Branch mode: i_branch_id=1, i_regwrite_mem=1, i_memtoreg_mem=0, i_rd_mem=5=i_rt_id (used) -> stall 0 when BR_FWD_MEM=1, stall 1 with o_cause=3 when BR_FWD_MEM=0.
REQ-029 MDU: MDU_LAT=4, start at edge N, i_mdu_use_id held 1 -> o_stall high cycles N..N+3, low at N+4; restart at N+2 -> busy through N+5.
REQ-030 Freeze: i_dmem_ready=0 with a load-use hazard present -> o_freeze=1, o_stall=0, o_flush_ifid=0, o_cause=3; i_mdu_start_ex ignored.
REQ-031 Counter: CNT_W=4, 20 stall cycles -> o_stall_cycles=15; i_cnt_clr with stall high -> 0 at next edge; reset mid-MDU -> busy 0 immediately.
